// File: rtl/wb_port_arb_pkg.sv
// Shared types and constants for the write-back port arbiter.
package wb_pkg;

  localparam int GPR_AW = 5;
  localparam logic [GPR_AW-1:0] REG_ZERO = 5'd0;

  // One buffered write request; killed marks an entry that a younger
  // pipeline write to the same register has already superseded.
  typedef struct packed {
    logic [GPR_AW-1:0] wd;
    logic [31:0]       wdata;
    logic              killed;
  } wb_req_t;

  // A write to r0 is never a real write.
  function automatic logic is_wr(input logic en, input logic [GPR_AW-1:0] wd);
    return en && (wd != REG_ZERO);
  endfunction

endpackage

// File: rtl/wb_port_arb_if.sv
// Bus bundle between the pipeline / long-latency unit and the WB arbiter.
interface wb_port_arb_if;
  import wb_pkg::*;

  // pipeline MEM-stage result
  logic [GPR_AW-1:0] mem_wd;
  logic              mem_reg;
  logic [31:0]       mem_wdata;
  // long-latency unit return
  logic              lu_valid;
  logic              lu_ready;
  logic [GPR_AW-1:0] lu_wd;
  logic [31:0]       lu_wdata;
  // ID-stage interlock lookup
  logic [GPR_AW-1:0] query_rs;
  logic [GPR_AW-1:0] query_rt;
  logic              pend_rs;
  logic              pend_rt;
  logic              stall_req;
  // registered write-back bundle
  logic [GPR_AW-1:0] wb_wd;
  logic              wb_reg;
  logic [31:0]       wb_wdata;

  // Requesters and consumers of the write port.
  modport master (
    output mem_wd, mem_reg, mem_wdata, lu_valid, lu_wd, lu_wdata, query_rs, query_rt,
    input  lu_ready, pend_rs, pend_rt, stall_req, wb_wd, wb_reg, wb_wdata
  );

  // The arbiter itself.
  modport slave (
    input  mem_wd, mem_reg, mem_wdata, lu_valid, lu_wd, lu_wdata, query_rs, query_rt,
    output lu_ready, pend_rs, pend_rt, stall_req, wb_wd, wb_reg, wb_wdata
  );

endinterface

// File: rtl/wb_pend_fifo.sv
// Circular buffer of pending long-latency writes with kill-by-register
// and two combinational pending-write lookup ports.
module wb_pend_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  wb_req_t                   push_req,
  input  logic                      pop,
  input  logic                      kill_en,
  input  logic [GPR_AW-1:0]         kill_wd,
  input  logic [GPR_AW-1:0]         q_a,
  input  logic [GPR_AW-1:0]         q_b,
  output logic                      hit_a,
  output logic                      hit_b,
  output wb_req_t                   head,
  output logic                      head_live,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);

  wb_req_t          slot_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;

  logic [DEPTH-1:0] live;
  logic [DEPTH-1:0] match_a;
  logic [DEPTH-1:0] match_b;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Slot payload: kill matching entries, then write the incoming one into the free tail slot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_en && (slot_reg[i].wd == kill_wd)) slot_reg[i].killed <= 1'b1;
    end
    if (push) slot_reg[wr_ptr_reg] <= push_req;
  end

  // A slot is occupied when its distance from the read pointer is below count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [PW-1:0] off;
    assign off         = PW'(gi) - rd_ptr_reg;
    assign live[gi]    = ({1'b0, off} < count_reg) && !slot_reg[gi].killed;
    assign match_a[gi] = live[gi] && (slot_reg[gi].wd == q_a);
    assign match_b[gi] = live[gi] && (slot_reg[gi].wd == q_b);
  end

  assign hit_a     = (q_a != REG_ZERO) && (|match_a);
  assign hit_b     = (q_b != REG_ZERO) && (|match_b);
  assign head      = slot_reg[rd_ptr_reg];
  assign head_live = (count_reg != '0) && !slot_reg[rd_ptr_reg].killed;
  assign count     = count_reg;

endmodule

// File: rtl/wb_port_arb.sv
// Write-back port arbiter: the pipeline always wins the register-file write
// port; long-latency results wait in a small FIFO and drain into idle slots.
module wb_port_arb
  import wb_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input logic         clk,
  input logic         rst,
  wb_port_arb_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic          pipe_win;
  logic          lu_ready;
  logic          push;
  logic          pop;
  wb_req_t       push_req;
  wb_req_t       head;
  logic          head_live;
  logic [CW-1:0] count;

  logic [GPR_AW-1:0] wb_wd_reg;
  logic              wb_reg_reg;
  logic [31:0]       wb_wdata_reg;
  logic [SW-1:0]     starve_reg;
  logic [SW-1:0]     starve_next;
  logic              stall_reg;
  logic              popped_reg;

  assign pipe_win = is_wr(bus.mem_reg, bus.mem_wd);
  // Ready depends only on state so the unit never sees a combinational path from the pipeline.
  assign lu_ready = !rst && (count < CW'(DEPTH));
  // Writes to r0 are acknowledged but never buffered.
  assign push     = bus.lu_valid && lu_ready && (bus.lu_wd != REG_ZERO);
  assign pop      = !pipe_win && (count != '0);

  assign push_req.wd     = bus.lu_wd;
  assign push_req.wdata  = bus.lu_wdata;
  assign push_req.killed = pipe_win && (bus.lu_wd == bus.mem_wd);

  wb_pend_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_req  (push_req),
    .pop       (pop),
    .kill_en   (pipe_win),
    .kill_wd   (bus.mem_wd),
    .q_a       (bus.query_rs),
    .q_b       (bus.query_rt),
    .hit_a     (bus.pend_rs),
    .hit_b     (bus.pend_rt),
    .head      (head),
    .head_live (head_live),
    .count     (count)
  );

  // Registered write-back bundle: pipeline first, then FIFO head, else idle with data held.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_wd_reg    <= REG_ZERO;
      wb_reg_reg   <= 1'b0;
      wb_wdata_reg <= '0;
    end else if (pipe_win) begin
      wb_wd_reg    <= bus.mem_wd;
      wb_reg_reg   <= 1'b1;
      wb_wdata_reg <= bus.mem_wdata;
    end else if (pop && head_live) begin
      wb_wd_reg    <= head.wd;
      wb_reg_reg   <= 1'b1;
      wb_wdata_reg <= head.wdata;
    end else begin
      wb_reg_reg   <= 1'b0;
    end
  end

  // Starvation count: cycles a live head lost to the pipeline, saturating.
  always_comb begin
    starve_next = starve_reg;
    if (pop || (count == '0)) begin
      starve_next = '0;
    end else if (pipe_win && head_live && (starve_reg < SW'(STARVE_MAX))) begin
      starve_next = starve_reg + 1'b1;
    end
  end

  // Stall request rises when the count saturates and falls one edge after a pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_reg <= '0;
      stall_reg  <= 1'b0;
      popped_reg <= 1'b0;
    end else begin
      starve_reg <= starve_next;
      popped_reg <= pop;
      if (popped_reg) begin
        stall_reg <= 1'b0;
      end else if (starve_next == SW'(STARVE_MAX)) begin
        stall_reg <= 1'b1;
      end
    end
  end

  assign bus.lu_ready  = lu_ready;
  assign bus.wb_wd     = wb_wd_reg;
  assign bus.wb_reg    = wb_reg_reg;
  assign bus.wb_wdata  = wb_wdata_reg;
  assign bus.stall_req = stall_reg;

endmodule

// File: tb/tb_wb_port_arb.sv
// Directed, table-driven bench for wb_port_arb.
module tb_wb_port_arb;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  wb_port_arb_if bus ();

  wb_port_arb #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        mr;
    logic [4:0]  mwd;
    logic [31:0] mdata;
    logic        lv;
    logic [4:0]  lwd;
    logic [31:0] ldata;
    logic [4:0]  qrs;
    logic [4:0]  qrt;
    logic        e_rdy;
    logic        e_prs;
    logic        e_prt;
    logic        e_wbr;
    logic        chk_data;
    logic [4:0]  e_wd;
    logic [31:0] e_wdata;
    logic        e_stall;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic mr, input logic [4:0] mwd, input logic [31:0] mdata,
    input logic lv, input logic [4:0] lwd, input logic [31:0] ldata,
    input logic [4:0] qrs, input logic [4:0] qrt,
    input logic e_rdy, input logic e_prs, input logic e_prt,
    input logic e_wbr, input logic chk_data, input logic [4:0] e_wd,
    input logic [31:0] e_wdata, input logic e_stall);
    vec_t v;
    v.mr = mr; v.mwd = mwd; v.mdata = mdata;
    v.lv = lv; v.lwd = lwd; v.ldata = ldata;
    v.qrs = qrs; v.qrt = qrt;
    v.e_rdy = e_rdy; v.e_prs = e_prs; v.e_prt = e_prt;
    v.e_wbr = e_wbr; v.chk_data = chk_data; v.e_wd = e_wd;
    v.e_wdata = e_wdata; v.e_stall = e_stall;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] mwd, input logic [31:0] mdata,
                       input logic lv, input logic [4:0] lwd, input logic [31:0] ldata,
                       input logic [4:0] qrs, input logic [4:0] qrt);
    bus.mem_reg = mr; bus.mem_wd = mwd; bus.mem_wdata = mdata;
    bus.lu_valid = lv; bus.lu_wd = lwd; bus.lu_wdata = ldata;
    bus.query_rs = qrs; bus.query_rt = qrt;
  endtask

  initial begin
    //          mr mwd mdata      lv lwd ldata      qrs qrt | rdy prs prt | wbr chk wd  wdata     stall
    // pipe only, then r0 write
    vq.push_back(mk(1, 8,  32'h1234, 0, 0,  32'h0,    0,  0,   1, 0, 0,   1, 1, 8,  32'h1234, 0));
    vq.push_back(mk(1, 0,  32'h5555, 0, 0,  32'h0,    0,  0,   1, 0, 0,   0, 1, 8,  32'h1234, 0));
    // drain: enqueue 3, pop it two edges later
    vq.push_back(mk(0, 0,  32'h0,    1, 3,  32'hAAAA, 3,  0,   1, 0, 0,   0, 1, 8,  32'h1234, 0));
    vq.push_back(mk(0, 0,  32'h0,    0, 0,  32'h0,    3,  0,   1, 1, 0,   1, 1, 3,  32'hAAAA, 0));
    vq.push_back(mk(0, 0,  32'h0,    0, 0,  32'h0,    3,  0,   1, 0, 0,   0, 1, 3,  32'hAAAA, 0));
    // full: two pushes under continuous pipe writes
    vq.push_back(mk(1, 10, 32'h100,  1, 11, 32'hB1,   0,  0,   1, 0, 0,   1, 1, 10, 32'h100,  0));
    vq.push_back(mk(1, 12, 32'h200,  1, 13, 32'hB2,   11, 13,  1, 1, 0,   1, 1, 12, 32'h200,  0));
    vq.push_back(mk(1, 14, 32'h300,  1, 15, 32'hB3,   11, 13,  0, 1, 1,   1, 1, 14, 32'h300,  0));
    vq.push_back(mk(0, 0,  32'h0,    0, 0,  32'h0,    11, 13,  0, 1, 1,   1, 1, 11, 32'hB1,   0));
    vq.push_back(mk(0, 0,  32'h0,    0, 0,  32'h0,    11, 13,  1, 0, 1,   1, 1, 13, 32'hB2,   0));
    vq.push_back(mk(0, 0,  32'h0,    0, 0,  32'h0,    11, 13,  1, 0, 0,   0, 1, 13, 32'hB2,   0));
    // kill of a buffered entry
    vq.push_back(mk(0, 0,  32'h0,    1, 5,  32'h5555, 5,  0,   1, 0, 0,   0, 1, 13, 32'hB2,   0));
    vq.push_back(mk(1, 5,  32'h6000, 0, 0,  32'h0,    5,  0,   1, 1, 0,   1, 1, 5,  32'h6000, 0));
    vq.push_back(mk(0, 0,  32'h0,    0, 0,  32'h0,    5,  0,   1, 0, 0,   0, 0, 0,  32'h0,    0));
    vq.push_back(mk(0, 0,  32'h0,    0, 0,  32'h0,    5,  0,   1, 0, 0,   0, 0, 0,  32'h0,    0));
    // kill of a same-cycle incoming entry
    vq.push_back(mk(1, 6,  32'h61,   1, 6,  32'h66,   6,  0,   1, 0, 0,   1, 1, 6,  32'h61,   0));
    vq.push_back(mk(0, 0,  32'h0,    0, 0,  32'h0,    6,  0,   1, 0, 0,   0, 0, 0,  32'h0,    0));
    // starvation
    vq.push_back(mk(0, 0,  32'h0,    1, 9,  32'h99,   9,  0,   1, 0, 0,   0, 0, 0,  32'h0,    0));
    vq.push_back(mk(1, 20, 32'h1,    0, 0,  32'h0,    9,  0,   1, 1, 0,   1, 1, 20, 32'h1,    0));
    vq.push_back(mk(1, 21, 32'h2,    0, 0,  32'h0,    9,  0,   1, 1, 0,   1, 1, 21, 32'h2,    0));
    vq.push_back(mk(1, 22, 32'h3,    0, 0,  32'h0,    9,  0,   1, 1, 0,   1, 1, 22, 32'h3,    0));
    vq.push_back(mk(1, 23, 32'h4,    0, 0,  32'h0,    9,  0,   1, 1, 0,   1, 1, 23, 32'h4,    1));
    vq.push_back(mk(1, 24, 32'h5,    0, 0,  32'h0,    9,  0,   1, 1, 0,   1, 1, 24, 32'h5,    1));
    vq.push_back(mk(0, 0,  32'h0,    0, 0,  32'h0,    9,  0,   1, 1, 0,   1, 1, 9,  32'h99,   1));
    vq.push_back(mk(0, 0,  32'h0,    0, 0,  32'h0,    9,  0,   1, 0, 0,   0, 1, 9,  32'h99,   0));

    // reset held two cycles with a long-latency request pending
    rst = 1'b1;
    drive(0, 0, 32'h0, 1, 7, 32'h77, 7, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst lu_ready", 32'(bus.lu_ready), 32'd0);
    chk("rst wb_reg", 32'(bus.wb_reg), 32'd0);
    chk("rst wb_wd", 32'(bus.wb_wd), 32'd0);
    chk("rst wb_wdata", bus.wb_wdata, 32'd0);
    chk("rst stall_req", 32'(bus.stall_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 32'h0, 0, 0, 32'h0, 7, 0);
    #1;
    chk("post-rst lu_ready", 32'(bus.lu_ready), 32'd1);
    chk("post-rst pend_rs", 32'(bus.pend_rs), 32'd0);
    $display("reset sequence done");

    // table-driven vectors
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].mr, vq[i].mwd, vq[i].mdata, vq[i].lv, vq[i].lwd, vq[i].ldata,
            vq[i].qrs, vq[i].qrt);
      #1;
      chk($sformatf("v%0d lu_ready", i), 32'(bus.lu_ready), 32'(vq[i].e_rdy));
      chk($sformatf("v%0d pend_rs", i), 32'(bus.pend_rs), 32'(vq[i].e_prs));
      chk($sformatf("v%0d pend_rt", i), 32'(bus.pend_rt), 32'(vq[i].e_prt));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d wb_reg", i), 32'(bus.wb_reg), 32'(vq[i].e_wbr));
      chk($sformatf("v%0d stall_req", i), 32'(bus.stall_req), 32'(vq[i].e_stall));
      if (vq[i].chk_data) begin
        chk($sformatf("v%0d wb_wd", i), 32'(bus.wb_wd), 32'(vq[i].e_wd));
        chk($sformatf("v%0d wb_wdata", i), bus.wb_wdata, vq[i].e_wdata);
      end
      $display("vec %0d: mem=%0b/%0d lu=%0b/%0d -> wb_reg=%0b wb_wd=%0d wb_wdata=%0h stall=%0b",
               i, vq[i].mr, vq[i].mwd, vq[i].lv, vq[i].lwd,
               bus.wb_reg, bus.wb_wd, bus.wb_wdata, bus.stall_req);
    end

    // reset mid-operation discards a full FIFO
    @(negedge clk);
    drive(1, 25, 32'h7, 1, 26, 32'hC1, 0, 0);
    @(negedge clk);
    drive(1, 27, 32'h8, 1, 28, 32'hC2, 26, 28);
    #1;
    chk("mid pend_rs before rst", 32'(bus.pend_rs), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 32'h0, 1, 29, 32'hC3, 26, 28);
    #1;
    chk("mid rst lu_ready", 32'(bus.lu_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("mid rst wb_reg", 32'(bus.wb_reg), 32'd0);
    chk("mid rst wb_wd", 32'(bus.wb_wd), 32'd0);
    chk("mid rst stall_req", 32'(bus.stall_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 32'h0, 0, 0, 32'h0, 26, 28);
    #1;
    chk("mid post pend_rs", 32'(bus.pend_rs), 32'd0);
    chk("mid post pend_rt", 32'(bus.pend_rt), 32'd0);
    chk("mid post lu_ready", 32'(bus.lu_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("mid post wb_reg", 32'(bus.wb_reg), 32'd0);
    chk("mid post wb_wd", 32'(bus.wb_wd), 32'd0);
    $display("mid-operation reset sequence done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arb.md
Name: wb_port_arb

Overview:
- Schedules the single register-file write port between two requesters: the in-order pipeline (MEM-stage result) and a long-latency unit (divider / uncached-load return).
- Replaces the plain MEM->WB register. Output is the registered WB write bundle.
- The pipeline always wins. Long-latency results are buffered in a small FIFO and drained into idle write slots.
- Provides pending-write lookup for ID-stage interlock, and a starvation stall request.

Parameters:
- DEPTH, 2, number of buffered long-latency write entries (power of two, >=2).
- STARVE_MAX, 4, consecutive lost arbitration cycles before stall_req asserts.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- mem_wd  in  5  pipeline destination register
- mem_reg  in  1  pipeline write enable
- mem_wdata  in  32  pipeline write data
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  FIFO can accept this cycle
- lu_wd  in  5  long-latency destination register
- lu_wdata  in  32  long-latency write data
- query_rs  in  5  ID-stage source register A
- query_rt  in  5  ID-stage source register B
- pend_rs  out  1  query_rs has a buffered pending write
- pend_rt  out  1  query_rt has a buffered pending write
- stall_req  out  1  request pipeline bubble to drain FIFO
- wb_wd  out  5  registered write register
- wb_reg  out  1  registered write enable
- wb_wdata  out  32  registered write data

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - While rst is high: wb_wd=0, wb_reg=0, wb_wdata=0, stall_req=0, lu_ready=0.
  - FIFO is emptied, starvation counter=0.
  - Reset mid-operation discards all buffered entries.
- Pipe win: when mem_reg=1 and mem_wd!=0, the next edge loads wb_* from mem_* (1-cycle latency). The pipeline is never back-pressured.
- mem_reg=1 with mem_wd=0 is treated as no request: wb_reg<=0 and the slot is free for the FIFO.
- FIFO drain: in a cycle with no pipe win and a non-empty FIFO, pop the head.
  - Head valid: wb_wd/wb_wdata<=head, wb_reg<=1.
  - Head killed: wb_reg<=0. The slot is consumed.
- Idle: no pipe win and FIFO empty gives wb_reg<=0. wb_wd/wb_wdata hold their previous values.
- Enqueue:
  - lu_ready = !rst && count<DEPTH. It is combinational from state only and does not depend on a same-cycle pop.
  - The handshake fires when lu_valid && lu_ready.
  - lu_wd=0 is accepted and dropped, with no enqueue.
  - Push and pop in the same cycle are legal.
  - The FIFO never bypasses: an enqueued entry is written no earlier than the edge after the next one.
- Kill rule: on a pipe win to register r, every buffered entry with wd==r is marked killed, and so is a same-cycle incoming entry with lu_wd==r. Killed entries still occupy their slots until popped.
- Pending lookup (combinational):
  - pend_rs=1 iff query_rs!=0 and some valid (non-killed) buffered entry has wd==query_rs. pend_rt is the same for query_rt.
  - Same-cycle incoming lu entries are excluded.
- Starvation:
  - The counter increments each cycle the FIFO head is valid and the pipe wins. It clears on any pop, or when the FIFO is empty.
  - The counter saturates at STARVE_MAX.
  - stall_req is registered: it is set on the edge where the counter reaches STARVE_MAX and cleared on the edge after the next pop.
- Pointers wrap modulo DEPTH. count is in 0..DEPTH.

Decomposition:
- Shared package wb_pkg:
  - typedef wb_req_t {wd[4:0], wdata[31:0], killed}
  - constant REG_ZERO=5'd0
  - constant GPR_AW=5
- One sub-module wb_pend_fifo: DEPTH-entry circular buffer with push/pop, per-entry kill-by-register, and two lookup ports. The top contains the arbitration, output registers and starvation logic.

Test Plan:
- Reset: rst high for 2 cycles with lu_valid=1 -> lu_ready=0, wb_reg=0, stall_req=0; after release lu_ready=1 and count=0.
- Pipe only: mem_reg=1, mem_wd=8, mem_wdata=0x1234 -> next edge wb_reg=1, wb_wd=8, wb_wdata=0x1234; with mem_wd=0 -> wb_reg=0.
- Drain: push lu_wd=3/0xAAAA with the pipe idle -> wb_reg=1 and wb_wd=3 two edges later; pend_rs(query_rs=3)=1 until the pop edge.
- Full: push 2 entries while the pipe writes every cycle -> lu_ready=0. After the first pipe bubble the head pops and lu_ready=1 the cycle after.
- Kill: buffer wd=5, then pipe writes wd=5 -> pend for 5 drops immediately; the later pop gives wb_reg=0 and no write of reg 5.
- Starvation: one buffered entry, pipe writes 4 consecutive cycles -> stall_req=1 after the 4th. Pipe bubble -> pop, then stall_req=0 one edge later.
